// File: rtl/hazard_controller_pkg.sv
// Shared pipeline constants: hazard FSM state encoding and multi-cycle latency default.
package hazard_controller_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MUL_BUSY = 1'b1
  } hz_state_t;

  localparam int MUL_LAT_DEFAULT = 4;
  localparam int MUL_CNT_W       = 4;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter used for the stall-cycle statistic.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: load-use stall, branch flush, multi-cycle EX occupancy
// and memory-wait freeze, plus a saturating count of cycles with the PC held.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int SIZE_REG = 5,
  parameter int MUL_LAT  = MUL_LAT_DEFAULT,
  parameter int SIZE_CNT = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SIZE_REG-1:0]  in_RS,
  input  logic [SIZE_REG-1:0]  in_RT,
  input  logic                 ID_EX_MemRead,
  input  logic [SIZE_REG-1:0]  in_id_ex_regRt,
  input  logic                 EX_BranchTaken,
  input  logic                 EX_MulStart,
  input  logic                 MEM_Wait,
  output logic                 PCWrite,
  output logic                 IF_ID_Write,
  output logic                 ID_EX_Write,
  output logic                 EX_MEM_Write,
  output logic                 IF_ID_Flush,
  output logic                 ID_EX_Bubble,
  output logic                 EX_MEM_Bubble,
  output logic                 MulDone,
  output logic [SIZE_CNT-1:0]  StallCount,
  output hz_state_t            fsm_state,
  output logic [MUL_CNT_W-1:0] mul_count
);

  localparam logic [MUL_CNT_W-1:0] MUL_LOAD = MUL_CNT_W'(MUL_LAT - 1);

  hz_state_t            state, next_state;
  logic [MUL_CNT_W-1:0] mul_cnt, next_cnt;
  logic                 load_use;

  assign load_use = ID_EX_MemRead && (in_id_ex_regRt != '0) &&
                    ((in_id_ex_regRt == in_RS) || (in_id_ex_regRt == in_RT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      mul_cnt <= '0;
    end else begin
      state   <= next_state;
      mul_cnt <= next_cnt;
    end
  end

  always_comb begin
    next_state    = state;
    next_cnt      = mul_cnt;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    ID_EX_Write   = 1'b1;
    EX_MEM_Write  = 1'b1;
    IF_ID_Flush   = 1'b0;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_Bubble = 1'b0;
    MulDone       = 1'b0;
    if (!rst_n) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (MEM_Wait) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Write  = 1'b0;
      EX_MEM_Write = 1'b0;
    end else if (state == MUL_BUSY) begin
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Bubble = 1'b1;
      next_cnt      = mul_cnt - 1'b1;
      // A zero count can only arise from a corrupted state; treat it as done.
      if (mul_cnt <= MUL_CNT_W'(1)) begin
        MulDone    = 1'b1;
        next_state = RUN;
        next_cnt   = '0;
      end
    end else if (EX_BranchTaken) begin
      IF_ID_Flush  = 1'b1;
      ID_EX_Bubble = 1'b1;
    end else if (EX_MulStart) begin
      // The entry cycle already holds upstream stages: it is the first busy cycle.
      PCWrite       = 1'b0;
      IF_ID_Write   = 1'b0;
      ID_EX_Write   = 1'b0;
      EX_MEM_Bubble = 1'b1;
      next_state    = MUL_BUSY;
      next_cnt      = MUL_LOAD;
    end else if (load_use) begin
      PCWrite      = 1'b0;
      IF_ID_Write  = 1'b0;
      ID_EX_Bubble = 1'b1;
    end
  end

  sat_counter #(.WIDTH(SIZE_CNT)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~PCWrite),
    .count (StallCount)
  );

  assign fsm_state = state;
  assign mul_count = mul_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller and a narrow sat_counter for saturation.
module tb_hazard_controller;
  import hazard_controller_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  in_RS, in_RT, in_id_ex_regRt;
  logic        ID_EX_MemRead, EX_BranchTaken, EX_MulStart, MEM_Wait;
  logic        PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write;
  logic        IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulDone;
  logic [15:0] StallCount;
  hz_state_t   fsm_state;
  logic [3:0]  mul_count;
  logic        sc_rst_n, sc_inc;
  logic [1:0]  sc_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_controller #(.SIZE_REG(5), .MUL_LAT(4), .SIZE_CNT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_RS(in_RS), .in_RT(in_RT),
    .ID_EX_MemRead(ID_EX_MemRead), .in_id_ex_regRt(in_id_ex_regRt),
    .EX_BranchTaken(EX_BranchTaken), .EX_MulStart(EX_MulStart), .MEM_Wait(MEM_Wait),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Write(ID_EX_Write),
    .EX_MEM_Write(EX_MEM_Write), .IF_ID_Flush(IF_ID_Flush), .ID_EX_Bubble(ID_EX_Bubble),
    .EX_MEM_Bubble(EX_MEM_Bubble), .MulDone(MulDone), .StallCount(StallCount),
    .fsm_state(fsm_state), .mul_count(mul_count)
  );

  sat_counter #(.WIDTH(2)) u_sat (
    .clk(clk), .rst_n(sc_rst_n), .inc(sc_inc), .count(sc_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write, Flush, IDEX_Bub, EXMEM_Bub, MulDone}
  function automatic logic [31:0] outs();
    return {24'd0, PCWrite, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
            IF_ID_Flush, ID_EX_Bubble, EX_MEM_Bubble, MulDone};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_RS = 5'd1; in_RT = 5'd2; in_id_ex_regRt = 5'd0;
    ID_EX_MemRead = 1'b0; EX_BranchTaken = 1'b0; EX_MulStart = 1'b0; MEM_Wait = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sc_rst_n = 1'b0; sc_inc = 1'b0;
    idle();
    #12;
    chk("rst_outs", outs(), 32'h00);
    chk("rst_stall", StallCount, 0);
    chk("rst_state", fsm_state, RUN);
    chk("rst_cnt", mul_count, 0);
    rst_n = 1'b1; sc_rst_n = 1'b1;
    tick();
    chk("idle_outs", outs(), 32'hF0);
    chk("idle_stall", StallCount, 0);

    // load-use on rs
    ID_EX_MemRead = 1'b1; in_id_ex_regRt = 5'd8; in_RS = 5'd8; in_RT = 5'd3;
    #1 chk("lu_rs_outs", outs(), 32'h34);
    tick(); idle();
    #1 chk("lu_rs_stall", StallCount, 1);
    chk("lu_rs_after", outs(), 32'hF0);
    chk("lu_state", fsm_state, RUN);

    // register zero never stalls
    ID_EX_MemRead = 1'b1; in_id_ex_regRt = 5'd0; in_RS = 5'd0;
    #1 chk("lu_r0_outs", outs(), 32'hF0);
    tick();
    chk("lu_r0_stall", StallCount, 1);

    // load-use on rt
    in_id_ex_regRt = 5'd5; in_RS = 5'd9; in_RT = 5'd5;
    #1 chk("lu_rt_outs", outs(), 32'h34);
    tick(); idle();
    chk("lu_rt_stall", StallCount, 2);

    // branch beats load-use and mul start
    ID_EX_MemRead = 1'b1; in_id_ex_regRt = 5'd8; in_RS = 5'd8;
    EX_BranchTaken = 1'b1; EX_MulStart = 1'b1;
    #1 chk("br_outs", outs(), 32'hFC);
    tick(); idle();
    chk("br_state", fsm_state, RUN);
    chk("br_stall", StallCount, 2);

    // plain multi-cycle op, MUL_LAT=4
    EX_MulStart = 1'b1;
    #1 chk("mul_entry", outs(), 32'h12);
    tick(); idle();
    chk("mul_b1_state", fsm_state, MUL_BUSY);
    chk("mul_b1_cnt", mul_count, 3);
    chk("mul_b1_outs", outs(), 32'h12);
    tick();
    chk("mul_b2_cnt", mul_count, 2);
    chk("mul_b2_outs", outs(), 32'h12);
    tick();
    chk("mul_b3_cnt", mul_count, 1);
    chk("mul_b3_outs", outs(), 32'h13);
    tick();
    chk("mul_end_state", fsm_state, RUN);
    chk("mul_end_outs", outs(), 32'hF0);
    chk("mul_stall", StallCount, 6);

    // multi-cycle op with a 2-cycle memory wait at mul_cnt=2
    EX_MulStart = 1'b1;
    tick(); idle();
    tick();
    chk("mw_cnt2", mul_count, 2);
    MEM_Wait = 1'b1;
    #1 chk("mw_outs", outs(), 32'h00);
    tick();
    chk("mw_hold1_cnt", mul_count, 2);
    chk("mw_hold1_state", fsm_state, MUL_BUSY);
    chk("mw_hold1_outs", outs(), 32'h00);
    tick();
    chk("mw_hold2_cnt", mul_count, 2);
    MEM_Wait = 1'b0;
    #1 chk("mw_resume_outs", outs(), 32'h12);
    tick();
    chk("mw_last_cnt", mul_count, 1);
    chk("mw_last_outs", outs(), 32'h13);
    tick();
    chk("mw_end_state", fsm_state, RUN);
    chk("mw_stall", StallCount, 12);

    // memory wait in RUN freezes everything, even a mul start and load-use
    MEM_Wait = 1'b1; EX_MulStart = 1'b1;
    ID_EX_MemRead = 1'b1; in_id_ex_regRt = 5'd8; in_RS = 5'd8;
    #1 chk("wrun_outs", outs(), 32'h00);
    tick(); idle();
    chk("wrun_state", fsm_state, RUN);
    chk("wrun_stall", StallCount, 13);

    // asynchronous reset in the middle of a busy period
    EX_MulStart = 1'b1;
    tick(); idle();
    tick();
    chk("ar_pre_state", fsm_state, MUL_BUSY);
    #2 rst_n = 1'b0;
    #1 chk("ar_state", fsm_state, RUN);
    chk("ar_cnt", mul_count, 0);
    chk("ar_stall", StallCount, 0);
    chk("ar_outs", outs(), 32'h00);
    tick();
    chk("ar_hold_outs", outs(), 32'h00);
    #2 rst_n = 1'b1;
    tick();
    chk("ar_post_outs", outs(), 32'hF0);
    chk("ar_post_stall", StallCount, 0);
    chk("ar_post_state", fsm_state, RUN);

    // saturation on a 2-bit instance
    sc_inc = 1'b1;
    tick(); tick();
    chk("sat_two", sc_count, 2);
    tick(); tick(); tick();
    chk("sat_max", sc_count, 3);
    sc_inc = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
